sm83_reg_bus_pch_seq: RTL and testbench
=======================================

Name: sm83_reg_bus_pch_seq

Overview:
Parametrised, clocked successor to the static two-line register-bus precharge cell. It owns NBUS register-file buses and runs a PRECHARGE/EVALUATE sequence on each one. During precharge it pulls the selected bus lines high. During evaluate it grants the register-file drivers access to the buses. Sits between the sm83 control decode and the register-file bus drivers; it also keeps a static always-precharge mode for compatibility with the old cell.

Parameters:
NBUS, 2, number of bus lines handled (≥1)
PCH_CYCLES, 1, clocks spent in PRECHARGE per sequence (≥1)
EVAL_CYCLES, 3, maximum clocks spent in EVALUATE per sequence (≥1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  synchronous reset, active low
start  input  1  request a precharge/evaluate sequence
bus_mask  input  NBUS  buses taking part in the sequence; latched on accepted start
hold_pch  input  1  static mode: keep masked buses precharged while IDLE
drv_req  input  NBUS  per-bus driver request from register file
eval_done  input  1  ends EVALUATE early
conflict_clr  input  1  clears sticky conflict flags
pch_n  output  NBUS  per-bus precharge enable, active low, registered
bus_y  output tri  NBUS  bus lines; driven strong1 when the matching pch_n is 0, otherwise highz
drv_gnt  output  NBUS  per-bus driver grant, registered
busy  output  1  high in PRECHARGE or EVALUATE
conflict  output  NBUS  sticky: a request hit a bus while it was precharging

Behaviour:
- Reset (reset_n=0 at clk edge):
  - state=IDLE, pch_n='1, bus_y=Z, drv_gnt=0, busy=0, conflict=0.
  - Counters and the latched mask (mask_l) clear to 0.
  - Reset mid-sequence aborts the sequence immediately with the same values.
- All outputs are registered: one clock of latency from input to output. bus_y follows pch_n combinationally.
- State IDLE:
  - hold_pch=1: pch_n[i]<=~bus_mask[i] (mask sampled live).
  - hold_pch=0: pch_n<='1.
  - drv_gnt[i]<=drv_req[i] & pch_n_next[i], where pch_n_next is the value being loaded into pch_n this edge. A bus never gets a grant while it is precharged.
  - start=1 (takes priority over hold_pch): mask_l<=bus_mask; pch_n<=~bus_mask; go to PCH; cnt<=PCH_CYCLES-1; busy<=1.
- State PCH:
  - pch_n=~mask_l; drv_gnt[i]<=drv_req[i] & ~mask_l[i].
  - When cnt=0: go to EVAL; pch_n<='1; cnt<=EVAL_CYCLES-1. Otherwise cnt decrements.
  - start, bus_mask and hold_pch are ignored in this state.
- State EVAL:
  - pch_n='1; drv_gnt[i]<=drv_req[i] (all buses).
  - Exit condition: cnt=0 or eval_done=1.
    - On exit with start=1: back-to-back, same as a start accepted from IDLE (new mask latched, pch_n<=~bus_mask, drv_gnt for newly masked buses forced to 0).
    - On exit with start=0: go to IDLE; busy<=0.
  - Otherwise cnt decrements; start is ignored except on the exit cycle.
- Conflict:
  - conflict[i] sets on the edge after drv_req[i]=1 while pch_n[i]=0 (PCH state or IDLE hold mode).
  - Sticky until conflict_clr=1. If set and clear happen on the same edge, set wins.
- Counters are $clog2(max(PCH_CYCLES,EVAL_CYCLES))+1 bits wide and never wrap: they load on entry and stop at 0.
- bus_mask=0 on start: the sequence still runs for full timing, but no line is precharged.

Test Plan:
1. Reset: hold reset_n=0 with start=1, hold_pch=1, drv_req='1 → pch_n=2'b11, bus_y=ZZ, drv_gnt=0, busy=0, conflict=0.
2. NBUS=2, PCH=1, EVAL=3; pulse start with bus_mask=2'b11:
   - pch_n=2'b00 and bus_y=2'b11 for 1 clock.
   - Then busy high for 3 EVAL clocks with bus_y=ZZ.
   - busy=1 for exactly 4 clocks in total.
3. In EVAL, assert drv_req=2'b10 → drv_gnt=2'b10 on the next clock. Assert eval_done → IDLE on the next edge, busy=0.
4. drv_req=2'b01 during PCH with mask=2'b01 → drv_gnt[0]=0, conflict=2'b01 and it stays set. conflict_clr=1 with no request → conflict=0. Clear plus a new conflict on the same edge → stays 1.
5. start held high through the last EVAL cycle with bus_mask=2'b10 → next clock pch_n=2'b01 with no IDLE cycle in between; busy stays high.
6. IDLE with hold_pch=1, bus_mask=2'b01 → pch_n=2'b10, bus_y[0]=1, bus_y[1]=Z. drv_req=2'b11 → drv_gnt=2'b10 and conflict[0]=1.

Source files
------------

// File: rtl/sm83_reg_bus_pch_seq.sv
// Clocked precharge/evaluate sequencer for the sm83 register-file buses.
// Keeps the old cell's static always-precharge behaviour through hold_pch while idle.
module sm83_reg_bus_pch_seq #(
    parameter int unsigned NBUS        = 2,
    parameter int unsigned PCH_CYCLES  = 1,
    parameter int unsigned EVAL_CYCLES = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [NBUS-1:0] bus_mask,
    input  logic            hold_pch,
    input  logic [NBUS-1:0] drv_req,
    input  logic            eval_done,
    input  logic            conflict_clr,
    output logic [NBUS-1:0] pch_n,
    output tri   [NBUS-1:0] bus_y,
    output logic [NBUS-1:0] drv_gnt,
    output logic            busy,
    output logic [NBUS-1:0] conflict
);

    localparam int unsigned CMAX = (PCH_CYCLES > EVAL_CYCLES) ? PCH_CYCLES : EVAL_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] PCH_LOAD  = CW'(PCH_CYCLES - 1);
    localparam logic [CW-1:0] EVAL_LOAD = CW'(EVAL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PCH,
        EVAL
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [NBUS-1:0] mask_q;
    logic [NBUS-1:0] pch_n_q;
    logic [NBUS-1:0] drv_gnt_q;
    logic [NBUS-1:0] conflict_q;
    logic            busy_q;

    logic [NBUS-1:0] idle_pch_n_d;
    logic [NBUS-1:0] conflict_d;
    logic            eval_exit;
    logic            accept;

    always_comb begin
        idle_pch_n_d = hold_pch ? ~bus_mask : '1;
        eval_exit    = (cnt_q == '0) || eval_done;
        // A start is honoured from IDLE or on the final EVAL cycle (back-to-back).
        accept       = start && ((state_q == IDLE) || ((state_q == EVAL) && eval_exit));
        // Set term is ORed after the clear so a simultaneous set wins.
        conflict_d   = (conflict_clr ? '0 : conflict_q) | (drv_req & ~pch_n_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mask_q     <= '0;
            pch_n_q    <= '1;
            drv_gnt_q  <= '0;
            conflict_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
            if (accept) begin
                state_q   <= PCH;
                mask_q    <= bus_mask;
                pch_n_q   <= ~bus_mask;
                drv_gnt_q <= drv_req & ~bus_mask;
                cnt_q     <= PCH_LOAD;
                busy_q    <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        pch_n_q   <= idle_pch_n_d;
                        drv_gnt_q <= drv_req & idle_pch_n_d;
                    end
                    PCH: begin
                        drv_gnt_q <= drv_req & ~mask_q;
                        if (cnt_q == '0) begin
                            state_q <= EVAL;
                            pch_n_q <= '1;
                            cnt_q   <= EVAL_LOAD;
                        end else begin
                            pch_n_q <= ~mask_q;
                            cnt_q   <= cnt_q - CW'(1);
                        end
                    end
                    EVAL: begin
                        pch_n_q   <= '1;
                        drv_gnt_q <= drv_req;
                        if (eval_exit) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        pch_n_q <= '1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < NBUS; g++) begin : g_bus
        assign bus_y[g] = pch_n_q[g] ? 1'bz : 1'b1;
    end

    assign pch_n    = pch_n_q;
    assign drv_gnt  = drv_gnt_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sm83_reg_bus_pch_seq.sv
// Scoreboard bench for sm83_reg_bus_pch_seq: directed steps queue the expected
// post-edge outputs, a negedge monitor pops and compares them.
module tb_sm83_reg_bus_pch_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] bus_mask;
  logic       hold_pch;
  logic [1:0] drv_req;
  logic       eval_done;
  logic       conflict_clr;
  logic [1:0] pch_n;
  wire  [1:0] bus_y;
  logic [1:0] drv_gnt;
  logic       busy;
  logic [1:0] conflict;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         at;
    logic [1:0] p;
    logic [1:0] g;
    logic       b;
    logic [1:0] c;
    string      nm;
  } exp_t;

  exp_t sb[$];

  sm83_reg_bus_pch_seq #(
    .NBUS       (2),
    .PCH_CYCLES (1),
    .EVAL_CYCLES(3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .bus_mask    (bus_mask),
    .hold_pch    (hold_pch),
    .drv_req     (drv_req),
    .eval_done   (eval_done),
    .conflict_clr(conflict_clr),
    .pch_n       (pch_n),
    .bus_y       (bus_y),
    .drv_gnt     (drv_gnt),
    .busy        (busy),
    .conflict    (conflict)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    exp_t e;
    logic bus_ok;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        bus_ok = 1'b1;
        for (int unsigned i = 0; i < 2; i++) begin
          if (e.p[i] == 1'b0) begin
            if (bus_y[i] !== 1'b1) bus_ok = 1'b0;
          end else begin
            if (bus_y[i] === 1'b1) bus_ok = 1'b0;
          end
        end
        if (e.at != cyc || {pch_n, drv_gnt, busy, conflict} !== {e.p, e.g, e.b, e.c} || !bus_ok) begin
          n_fail++;
          $display("FAIL %s @cyc %0d (due %0d): got pch_n=%b bus_y=%b drv_gnt=%b busy=%b conflict=%b, want pch_n=%b drv_gnt=%b busy=%b conflict=%b",
                   e.nm, cyc, e.at, pch_n, bus_y, drv_gnt, busy, conflict, e.p, e.g, e.b, e.c);
        end
      end
    end
  end

  task automatic step(input logic rn, input logic st, input logic [1:0] m, input logic h,
                      input logic [1:0] r, input logic d, input logic c,
                      input logic [1:0] ep, input logic [1:0] eg, input logic eb,
                      input logic [1:0] ec, input string nm);
    exp_t e;
    reset_n      = rn;
    start        = st;
    bus_mask     = m;
    hold_pch     = h;
    drv_req      = r;
    eval_done    = d;
    conflict_clr = c;
    e.at = cyc + 1;
    e.p  = ep;
    e.g  = eg;
    e.b  = eb;
    e.c  = ec;
    e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //    rn st  mask  h  req  d  c   pch   gnt   b  conf
    step(0, 1, 2'b11, 1, 2'b11, 0, 0, 2'b11, 2'b00, 0, 2'b00, "reset_a");
    step(0, 1, 2'b11, 1, 2'b11, 0, 0, 2'b11, 2'b00, 0, 2'b00, "reset_b");
    n_checks++;
    if (bus_y !== 2'bzz) begin
      n_fail++;
      $display("FAIL direct reset bus_y=%b want zz", bus_y);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL direct reset busy=%b want 0", busy);
    end
    step(1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b11, 2'b00, 0, 2'b00, "idle");

    step(1, 1, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 2'b00, "t2_pch");
    n_checks++;
    if (bus_y !== 2'b11) begin
      n_fail++;
      $display("FAIL direct t2_pch bus_y=%b want 11", bus_y);
    end
    step(1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b11, 2'b00, 1, 2'b00, "t2_eval1");
    n_checks++;
    if (bus_y !== 2'bzz) begin
      n_fail++;
      $display("FAIL direct t2_eval1 bus_y=%b want zz", bus_y);
    end
    step(1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b11, 2'b00, 1, 2'b00, "t2_eval2");
    step(1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b11, 2'b00, 1, 2'b00, "t2_eval3");
    step(1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b11, 2'b00, 0, 2'b00, "t2_idle");

    step(1, 1, 2'b00, 0, 2'b00, 0, 0, 2'b11, 2'b00, 1, 2'b00, "t3_pch_nomask");
    step(1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b11, 2'b00, 1, 2'b00, "t3_eval1");
    step(1, 0, 2'b00, 0, 2'b10, 0, 0, 2'b11, 2'b10, 1, 2'b00, "t3_gnt");
    step(1, 0, 2'b00, 0, 2'b00, 1, 0, 2'b11, 2'b00, 0, 2'b00, "t3_done");

    step(1, 1, 2'b01, 0, 2'b00, 0, 0, 2'b10, 2'b00, 1, 2'b00, "t4_pch");
    step(1, 0, 2'b00, 0, 2'b01, 0, 0, 2'b11, 2'b00, 1, 2'b01, "t4_conf");
    step(1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b11, 2'b00, 1, 2'b01, "t4_sticky");
    step(1, 0, 2'b00, 0, 2'b00, 0, 1, 2'b11, 2'b00, 1, 2'b00, "t4_clr");
    step(1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b11, 2'b00, 0, 2'b00, "t4_idle");

    step(1, 0, 2'b01, 1, 2'b00, 0, 0, 2'b10, 2'b00, 0, 2'b00, "t6_hold");
    n_checks++;
    if (bus_y !== 2'bz1) begin
      n_fail++;
      $display("FAIL direct t6_hold bus_y=%b want z1", bus_y);
    end
    step(1, 0, 2'b01, 1, 2'b11, 0, 0, 2'b10, 2'b10, 0, 2'b01, "t6_conf");
    step(1, 0, 2'b01, 1, 2'b01, 0, 1, 2'b10, 2'b00, 0, 2'b01, "t4_setwins");
    n_checks++;
    if (conflict !== 2'b01) begin
      n_fail++;
      $display("FAIL direct t4_setwins conflict=%b want 01", conflict);
    end
    step(1, 0, 2'b00, 0, 2'b00, 0, 1, 2'b11, 2'b00, 0, 2'b00, "t4_clr2");

    step(1, 1, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 2'b00, "t5_pch");
    step(1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b11, 2'b00, 1, 2'b00, "t5_eval1");
    step(1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b11, 2'b00, 1, 2'b00, "t5_eval2");
    step(1, 1, 2'b10, 0, 2'b00, 0, 0, 2'b11, 2'b00, 1, 2'b00, "t5_start_ignored");
    step(1, 1, 2'b10, 0, 2'b11, 0, 0, 2'b01, 2'b01, 1, 2'b00, "t5_b2b");
    n_checks++;
    if (pch_n !== 2'b01 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL direct t5_b2b pch_n=%b busy=%b want 01/1", pch_n, busy);
    end
    step(1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b11, 2'b00, 1, 2'b00, "t5_eval");
    step(1, 0, 2'b00, 0, 2'b00, 1, 0, 2'b11, 2'b00, 0, 2'b00, "t5_done");

    step(1, 1, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 2'b00, "rst_pch");
    step(0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b11, 2'b00, 0, 2'b00, "rst_mid");
    step(1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b11, 2'b00, 0, 2'b00, "post_rst");

    for (int unsigned k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: never compared (due cycle %0d, now %0d)", e.nm, e.at, cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
